// File: rtl/lpc_pkg.sv
// Shared widths, types and the output saturation helper for the LPC synthesiser.
package lpc_pkg;

    localparam int          LPC_ORDER = 10;
    localparam int          SAMPLE_W  = 16;
    localparam int          COEF_FRAC = 12;
    localparam int          ACC_W     = 40;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SAMPLE_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    localparam acc_t SAT_MAX = 40'sd32767;
    localparam acc_t SAT_MIN = -40'sd32768;

    function automatic sample_t sat16(input acc_t a);
        if (a > SAT_MAX)
            sat16 = 16'sh7fff;
        else if (a < SAT_MIN)
            sat16 = 16'sh8000;
        else
            sat16 = sample_t'(a[SAMPLE_W-1:0]);
    endfunction

endpackage

// File: rtl/lpc_excitation_gen.sv
// Excitation source: pitch pulse train or Galois LFSR noise, one value per v strobe.
module lpc_excitation_gen
    import lpc_pkg::*;
#(
    parameter sample_t     PULSE_AMP   = 16'sd8192,
    parameter int          NOISE_SHIFT = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          v,
    input  logic          voiced,
    input  logic [15:0]   pulserate,
    output sample_t       e
);

    logic [15:0] pc;
    logic [15:0] pc_eff;
    logic [15:0] pc_next;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    // pc_eff folds a stale count back to zero when a shorter pitch period is latched.
    always_comb begin
        pc_eff    = (pc >= pulserate) ? 16'd0 : pc;
        pc_next   = pc;
        e         = '0;
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
        if (voiced) begin
            if (pulserate != 16'd0 && pc_eff == 16'd0)
                e = PULSE_AMP;
            if (pulserate == 16'd0 || pc_eff == pulserate - 16'd1)
                pc_next = 16'd0;
            else
                pc_next = pc_eff + 16'd1;
        end else begin
            e = sample_t'($signed(lfsr) >>> NOISE_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc   <= 16'd0;
            lfsr <= LFSR_SEED;
        end else if (v) begin
            pc   <= pc_next;
            lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/lpc_decoder.sv
// 10th-order all-pole LPC synthesiser: frame latch, 11-term MAC, saturation, history.
// Handshake: v=1 in a cycle consumes one sample slot; vout=1 the following cycle with synth valid. No backpressure.
module lpc_decoder
    import lpc_pkg::*;
#(
    parameter int          FRAC_BITS   = COEF_FRAC,
    parameter sample_t     PULSE_AMP   = 16'sd8192,
    parameter int          NOISE_SHIFT = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               v,
    input  logic               voiced,
    input  logic [15:0]        pulserate,
    input  logic [15:0]        lpcrate,
    input  logic signed [15:0] A0,
    input  logic signed [15:0] A1,
    input  logic signed [15:0] A2,
    input  logic signed [15:0] A3,
    input  logic signed [15:0] A4,
    input  logic signed [15:0] A5,
    input  logic signed [15:0] A6,
    input  logic signed [15:0] A7,
    input  logic signed [15:0] A8,
    input  logic signed [15:0] A9,
    input  logic signed [15:0] A10,
    output logic signed [15:0] synth,
    output logic               vout
);

    logic [15:0]        fc;
    logic               latch;
    coef_t              coef_in  [0:LPC_ORDER];
    coef_t              coef_q   [0:LPC_ORDER];
    coef_t              coef_eff [0:LPC_ORDER];
    logic               voiced_q;
    logic               voiced_eff;
    logic [15:0]        pr_q;
    logic [15:0]        pr_eff;
    sample_t            hist     [0:LPC_ORDER-1];
    logic signed [31:0] prod     [0:LPC_ORDER];
    acc_t               acc;
    sample_t            e;
    sample_t            y;

    assign latch = v && (fc == 16'd0);

    assign coef_in[0]  = A0;
    assign coef_in[1]  = A1;
    assign coef_in[2]  = A2;
    assign coef_in[3]  = A3;
    assign coef_in[4]  = A4;
    assign coef_in[5]  = A5;
    assign coef_in[6]  = A6;
    assign coef_in[7]  = A7;
    assign coef_in[8]  = A8;
    assign coef_in[9]  = A9;
    assign coef_in[10] = A10;

    // A latching sample uses the live inputs directly, so the new frame starts on that sample.
    always_comb begin
        for (int k = 0; k <= LPC_ORDER; k++)
            coef_eff[k] = latch ? coef_in[k] : coef_q[k];
        voiced_eff = latch ? voiced : voiced_q;
        pr_eff     = latch ? pulserate : pr_q;
    end

    lpc_excitation_gen #(
        .PULSE_AMP   (PULSE_AMP),
        .NOISE_SHIFT (NOISE_SHIFT),
        .LFSR_SEED   (LFSR_SEED)
    ) u_exc (
        .clk       (clk),
        .rst       (rst),
        .v         (v),
        .voiced    (voiced_eff),
        .pulserate (pr_eff),
        .e         (e)
    );

    always_comb begin
        prod[0] = coef_eff[0] * e;
        for (int k = 1; k <= LPC_ORDER; k++)
            prod[k] = coef_eff[k] * hist[k-1];
        acc = acc_t'(prod[0]);
        for (int k = 1; k <= LPC_ORDER; k++)
            acc = acc - acc_t'(prod[k]);
        y = sat16(acc >>> FRAC_BITS);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fc       <= 16'd0;
            voiced_q <= 1'b0;
            pr_q     <= 16'd0;
            synth    <= '0;
            vout     <= 1'b0;
            for (int k = 0; k <= LPC_ORDER; k++)
                coef_q[k] <= '0;
            for (int k = 0; k < LPC_ORDER; k++)
                hist[k] <= '0;
        end else begin
            vout <= v;
            if (v) begin
                if (lpcrate <= 16'd1 || fc >= lpcrate - 16'd1)
                    fc <= 16'd0;
                else
                    fc <= fc + 16'd1;
                if (latch) begin
                    voiced_q <= voiced;
                    pr_q     <= pulserate;
                    for (int k = 0; k <= LPC_ORDER; k++)
                        coef_q[k] <= coef_in[k];
                end
                synth   <= y;
                hist[0] <= y;
                for (int k = 1; k < LPC_ORDER; k++)
                    hist[k] <= hist[k-1];
            end
        end
    end

endmodule

// File: tb/tb_lpc_decoder.sv
// Bench for lpc_decoder: vector table plus hand sequences, outputs checked through an expected-value queue.
module tb_lpc_decoder;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               v = 1'b0;
    logic               voiced = 1'b0;
    logic [15:0]        pulserate = '0;
    logic [15:0]        lpcrate = '0;
    logic signed [15:0] A [0:10];
    logic signed [15:0] synth;
    logic               vout;

    logic [15:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic               rst_before;
        logic signed [15:0] a0;
        logic signed [15:0] a1;
        logic               voiced;
        logic [15:0]        pr;
        logic [15:0]        lr;
        logic signed [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    lpc_decoder dut (
        .clk(clk), .rst(rst), .v(v), .voiced(voiced),
        .pulserate(pulserate), .lpcrate(lpcrate),
        .A0(A[0]), .A1(A[1]), .A2(A[2]), .A3(A[3]), .A4(A[4]), .A5(A[5]),
        .A6(A[6]), .A7(A[7]), .A8(A[8]), .A9(A[9]), .A10(A[10]),
        .synth(synth), .vout(vout)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every vout pulse consumes the oldest expected sample.
    always @(negedge clk) begin
        if (vout) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_vout: got synth %0d with no expected sample", synth);
            end else begin
                check("synth", int'(synth), int'($signed(exp_q.pop_front())));
            end
        end
    end

    function automatic vec_t mk(input logic r, input int a0, input int a1, input logic vc,
                                input int pr, input int lr, input int ex);
        vec_t t;
        t.rst_before = r;
        t.a0 = 16'(a0);
        t.a1 = 16'(a1);
        t.voiced = vc;
        t.pr = 16'(pr);
        t.lr = 16'(lr);
        t.exp = 16'(ex);
        return t;
    endfunction

    task automatic apply(input logic vv, input logic signed [15:0] ex);
        v = vv;
        if (vv) exp_q.push_back(ex);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        v = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic zero_coefs();
        for (int k = 0; k <= 10; k++) A[k] = '0;
    endtask

    initial begin
        logic [15:0]        m;
        logic signed [15:0] ne;
        int                 decay;

        zero_coefs();

        // Impulse train
        for (int n = 0; n < 8; n++)
            tbl.push_back(mk(n == 0, 4096, 0, 1, 4, 240, (n % 4 == 0) ? 8192 : 0));
        // One-pole decay (reset lands mid-frame of the previous scenario)
        decay = 8192;
        for (int n = 0; n < 16; n++) begin
            tbl.push_back(mk(n == 0, 4096, -2048, 1, 100, 240, decay));
            decay = decay / 2;
        end
        // Saturation at +32767
        tbl.push_back(mk(1, 4096, -8192, 1, 100, 240, 8192));
        tbl.push_back(mk(0, 4096, -8192, 1, 100, 240, 16384));
        for (int n = 0; n < 3; n++)
            tbl.push_back(mk(0, 4096, -8192, 1, 100, 240, 32767));
        // Frame latch: A1 changes after sample 1, takes effect at sample 4
        tbl.push_back(mk(1, 4096, 0, 1, 4, 4, 8192));
        tbl.push_back(mk(0, 4096, 0, 1, 4, 4, 0));
        tbl.push_back(mk(0, 4096, -2048, 1, 4, 4, 0));
        tbl.push_back(mk(0, 4096, -2048, 1, 4, 4, 0));
        tbl.push_back(mk(0, 4096, -2048, 1, 4, 4, 8192));
        tbl.push_back(mk(0, 4096, -2048, 1, 4, 4, 4096));
        tbl.push_back(mk(0, 4096, -2048, 1, 4, 4, 2048));
        tbl.push_back(mk(0, 4096, -2048, 1, 4, 4, 1024));
        tbl.push_back(mk(0, 4096, -2048, 1, 4, 4, 8704));
        // pulserate 0 is silence
        for (int n = 0; n < 3; n++)
            tbl.push_back(mk(n == 0, 4096, 0, 1, 0, 240, 0));
        // lpcrate 0 latches every sample
        tbl.push_back(mk(1, 4096, 0, 1, 100, 0, 8192));
        tbl.push_back(mk(0, 4096, -2048, 1, 100, 0, 4096));
        tbl.push_back(mk(0, 4096, -2048, 1, 100, 0, 2048));
        // Newly latched shorter pulserate folds pc back to 0
        for (int n = 0; n < 6; n++)
            tbl.push_back(mk(n == 0, 4096, 0, 1, 100, 2, (n == 0) ? 8192 : 0));
        tbl.push_back(mk(0, 4096, 0, 1, 3, 2, 8192));
        tbl.push_back(mk(0, 4096, 0, 1, 3, 2, 0));
        tbl.push_back(mk(0, 4096, 0, 1, 3, 2, 0));
        tbl.push_back(mk(0, 4096, 0, 1, 3, 2, 8192));
        // Gain and negative saturation
        tbl.push_back(mk(1, 2048, 0, 1, 100, 240, 4096));
        tbl.push_back(mk(1, -20000, 0, 1, 100, 240, -32768));

        // Reset held with v=1: outputs stay cleared
        A[0] = 16'sd4096;
        voiced = 1'b1;
        pulserate = 16'd4;
        lpcrate = 16'd240;
        rst = 1'b0;
        v = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_synth", int'(synth), 0);
            check("reset_vout", int'(vout), 0);
        end
        rst = 1'b1;
        exp_q.push_back(16'sd8192);
        @(posedge clk);
        #1;
        v = 1'b0;
        @(negedge clk);
        check("first_vout", int'(vout), 1);
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            zero_coefs();
            A[0] = tbl[i].a0;
            A[1] = tbl[i].a1;
            voiced = tbl[i].voiced;
            pulserate = tbl[i].pr;
            lpcrate = tbl[i].lr;
            apply(1'b1, tbl[i].exp);
        end

        // Higher taps: each Ak=-4096 echoes the impulse k samples later
        for (int k = 2; k <= 10; k++) begin
            do_reset();
            zero_coefs();
            A[0] = 16'sd4096;
            A[k] = -16'sd4096;
            voiced = 1'b1;
            pulserate = 16'd100;
            lpcrate = 16'd240;
            for (int n = 0; n <= k; n++)
                apply(1'b1, (n == 0 || n == k) ? 16'sd8192 : 16'sd0);
        end

        // Noise with v every third cycle, against a reference LFSR
        do_reset();
        zero_coefs();
        A[0] = 16'sd4096;
        voiced = 1'b0;
        pulserate = 16'd4;
        lpcrate = 16'd240;
        m = 16'hACE1;
        for (int n = 0; n < 12; n++) begin
            ne = $signed(m) >>> 3;
            m = (m >> 1) ^ (m[0] ? 16'hB400 : 16'h0000);
            apply(1'b1, ne);
            v = 1'b0;
            repeat (2) begin
                @(posedge clk);
                @(negedge clk);
                check("gap_vout", int'(vout), 0);
                check("gap_hold", int'(synth), int'(ne));
            end
        end
        v = 1'b0;

        for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
